// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot/program loader for the single-cycle core. A byte stream (valid/ready,
// typically from a UART receiver) carries a 16-bit little-endian word count N
// followed by 4*N payload bytes. Each group of four little-endian bytes is
// assembled into a 32-bit instruction word and written to instruction memory.
// The core is held in reset while loading. It is released once the final word
// has been written, and last_pc then tells it the index of the last loaded word.
//
// Ports
//   clk         in   1       system clock, all logic on posedge
//   rst         in   1       synchronous, active-high reset
//   in_data     in   8       stream byte
//   in_valid    in   1       in_data valid
//   in_ready    out  1       loader accepts a byte (decoded from state and reload)
//   reload      in   1       1-cycle pulse: abort and restart the load
//   imem_we     out  1       instruction memory write strobe (1 cycle per word)
//   imem_addr   out  ADDR_W  word address of the write
//   imem_wdata  out  32      word to write
//   core_rst    out  1       hold core in reset (1 = held)
//   last_pc     out  32      index of the last loaded word (N-1) once running
//   busy        out  1       loader is in a header/load/flush state
//   err         out  1       bad header seen; sticky until reload/rst
//
// Every output except in_ready is driven directly from a register. in_ready is
// decoded from the state and gated by reload. It never depends on in_valid, so
// the upstream valid/ready handshake has no combinational loop.
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic [31:0]       last_pc,
    output logic              busy,
    output logic              err
);

    // Memory depth as a 17-bit value, so that a full 16-bit header count can be
    // compared against it without overflow (ADDR_W is at most 16).
    localparam logic [16:0] DEPTH_C = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_LOAD  = 3'd2,
        S_FLUSH = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_r;
    logic [15:0]       n_r;          // word count taken from the header
    logic [ADDR_W-1:0] word_idx_r;   // index of the word being assembled
    logic [1:0]        byte_idx_r;   // byte position within that word
    logic [31:0]       word_r;       // shift register holding partial word

    // Registered outputs
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              core_rst_r;
    logic [31:0]       last_pc_r;
    logic              busy_r;
    logic              err_r;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              in_ready_s;
    logic              accept_s;
    logic [15:0]       n_hdr_s;      // full header count as of HDR1 byte
    logic              hdr_bad_s;
    logic              last_word_s;
    logic [31:0]       word_next_s;  // partial word after shifting in_data

    // Ready depends only on the state, and a reload in the same cycle blocks it.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            S_HDR0:  in_ready_s = ~reload;
            S_HDR1:  in_ready_s = ~reload;
            S_LOAD:  in_ready_s = ~reload;
            S_FLUSH: in_ready_s = 1'b0;
            S_RUN:   in_ready_s = 1'b0;
            S_ERR:   in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = in_valid & in_ready_s;

    // Header validation and word-assembly helpers.
    always_comb begin
        n_hdr_s     = {in_data, n_r[7:0]};
        hdr_bad_s   = (n_hdr_s == 16'd0) || ({1'b0, n_hdr_s} > DEPTH_C);
        last_word_s = (17'(word_idx_r) == (17'(n_r) - 17'd1));
        // Little-endian assembly: the byte shifts in from the top, so after
        // four bytes the first byte sits in bits 7:0.
        word_next_s = {in_data, word_r[31:8]};
    end

    // ------------------------------------------------------------------
    // Loader FSM with registered outputs
    // ------------------------------------------------------------------
    // Sequences header capture, word assembly, the memory writes and core release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_HDR0;
            n_r          <= 16'd0;
            word_idx_r   <= '0;
            byte_idx_r   <= 2'd0;
            word_r       <= 32'd0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
            core_rst_r   <= 1'b1;
            last_pc_r    <= 32'd0;
            busy_r       <= 1'b1;
            err_r        <= 1'b0;
        end else if (reload) begin
            // Abort from any state. A partially assembled word is dropped.
            // Words already in memory are left as they are.
            state_r      <= S_HDR0;
            n_r          <= 16'd0;
            word_idx_r   <= '0;
            byte_idx_r   <= 2'd0;
            word_r       <= 32'd0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
            core_rst_r   <= 1'b1;
            last_pc_r    <= 32'd0;
            busy_r       <= 1'b1;
            err_r        <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            imem_we_r <= 1'b0;

            case (state_r)
                S_HDR0: begin
                    if (accept_s) begin
                        n_r     <= {8'd0, in_data};
                        state_r <= S_HDR1;
                    end else begin
                        state_r <= S_HDR0;
                    end
                end

                S_HDR1: begin
                    if (accept_s) begin
                        n_r <= n_hdr_s;
                        if (hdr_bad_s) begin
                            state_r <= S_ERR;
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r    <= S_LOAD;
                            word_idx_r <= '0;
                            byte_idx_r <= 2'd0;
                        end
                    end else begin
                        state_r <= S_HDR1;
                    end
                end

                S_LOAD: begin
                    if (accept_s) begin
                        word_r     <= word_next_s;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            // Word complete: the write appears in the next cycle.
                            // Loading continues in parallel with that write.
                            imem_we_r    <= 1'b1;
                            imem_addr_r  <= word_idx_r;
                            imem_wdata_r <= word_next_s;
                            if (last_word_s) begin
                                // Index stays at N-1, so N == DEPTH never wraps.
                                state_r <= S_FLUSH;
                            end else begin
                                word_idx_r <= word_idx_r + 1'b1;
                                state_r    <= S_LOAD;
                            end
                        end else begin
                            state_r <= S_LOAD;
                        end
                    end else begin
                        state_r <= S_LOAD;
                    end
                end

                S_FLUSH: begin
                    // The final word is being written this cycle. Release the
                    // core from the next edge onwards.
                    state_r    <= S_RUN;
                    core_rst_r <= 1'b0;
                    last_pc_r  <= 32'(n_r) - 32'd1;
                    busy_r     <= 1'b0;
                end

                S_RUN: begin
                    state_r <= S_RUN;
                end

                S_ERR: begin
                    state_r <= S_ERR;
                end

                default: begin
                    // Unreachable encodings recover to a safe, core-held state.
                    state_r    <= S_ERR;
                    err_r      <= 1'b1;
                    core_rst_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign in_ready   = in_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign core_rst   = core_rst_r;
    assign last_pc    = last_pc_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule
